// File: rtl/comp_serial_nbits_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package comp_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    // Bit positions of the LG/EQ/SM trio inside the packed result register.
    localparam int RES_LG = 2;
    localparam int RES_EQ = 1;
    localparam int RES_SM = 0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [2:0] res_onehot(input int pos);
        return 3'(1) << pos;
    endfunction

endpackage

// File: rtl/comp_serial_nbits_if.sv
// Request/result bundle of the serial comparator.
interface comp_serial_nbits_if #(parameter int WIDTH = 8);
    logic             START;
    logic             SIGNED_MODE;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             BUSY;
    logic             DONE;
    logic             LG;
    logic             EQ;
    logic             SM;

    modport master (output START, SIGNED_MODE, X, Y,
                    input  BUSY, DONE, LG, EQ, SM);
    modport slave  (input  START, SIGNED_MODE, X, Y,
                    output BUSY, DONE, LG, EQ, SM);
endinterface

// File: rtl/comp_serial_nbits_digit.sv
// Combinational DIGIT-bit unsigned compare slice.
module comp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt
);
    assign gt = (a > b);
    assign lt = (a < b);
endmodule

// File: rtl/comp_serial_nbits.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock with early exit.
module comp_serial_nbits
    import comp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic               CLK,
    input  logic               RST,
    comp_serial_nbits_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = clog2(NDIG + 1);
    localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $fatal(1, "comp_serial_nbits: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
    end

    state_t           state;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [CW-1:0]    cnt;
    logic             done_q;
    logic [2:0]       res_q;
    logic             gt;
    logic             lt;

    comp_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (xs[WIDTH-1 -: DIGIT]),
        .b  (ys[WIDTH-1 -: DIGIT]),
        .gt (gt),
        .lt (lt)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            xs     <= '0;
            ys     <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        // Flipping both sign bits maps two's complement onto offset
                        // binary, so the unsigned digit compare stays valid.
                        xs    <= bus.X ^ (bus.SIGNED_MODE ? SIGN_BIT : '0);
                        ys    <= bus.Y ^ (bus.SIGNED_MODE ? SIGN_BIT : '0);
                        cnt   <= CW'(NDIG);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (gt) begin
                        res_q  <= res_onehot(RES_LG);
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else if (lt) begin
                        res_q  <= res_onehot(RES_SM);
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else if (cnt == CW'(1)) begin
                        res_q  <= res_onehot(RES_EQ);
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        xs  <= xs << DIGIT;
                        ys  <= ys << DIGIT;
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.BUSY = (state == RUN);
    assign bus.DONE = done_q;
    assign bus.LG   = res_q[RES_LG];
    assign bus.EQ   = res_q[RES_EQ];
    assign bus.SM   = res_q[RES_SM];

endmodule

// File: tb/tb_comp_serial_nbits.sv
// Scoreboard bench: three comparator configurations, expected results queued at START.
module tb_comp_serial_nbits;

    typedef struct {
        int         id;
        logic [2:0] res;
        int         start;
        int         lat;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   ndone [3];
    logic [2:0] last [3];
    exp_t q [$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    comp_serial_nbits_if #(.WIDTH(8)) b8  ();
    comp_serial_nbits_if #(.WIDTH(4)) b41 ();
    comp_serial_nbits_if #(.WIDTH(4)) b42 ();

    comp_serial_nbits #(.WIDTH(8), .DIGIT(2)) u8  (.CLK(CLK), .RST(RST), .bus(b8));
    comp_serial_nbits #(.WIDTH(4), .DIGIT(1)) u41 (.CLK(CLK), .RST(RST), .bus(b41));
    comp_serial_nbits #(.WIDTH(4), .DIGIT(2)) u42 (.CLK(CLK), .RST(RST), .bus(b42));

    logic       dv [3];
    logic [2:0] rv [3];
    assign dv[0] = b8.DONE;
    assign dv[1] = b41.DONE;
    assign dv[2] = b42.DONE;
    assign rv[0] = {b8.LG,  b8.EQ,  b8.SM};
    assign rv[1] = {b41.LG, b41.EQ, b41.SM};
    assign rv[2] = {b42.LG, b42.EQ, b42.SM};

    // Behavioural reference: integer compare plus first-differing-digit search.
    function automatic void ref_cmp(input int x, input int y, input int m, input int w,
                                    input int d, output logic [2:0] res, output int lat);
        int sx, sy, nd;
        sx = x; sy = y; nd = w / d;
        if (m != 0) begin
            if (x >= (1 << (w - 1))) sx = x - (1 << w);
            if (y >= (1 << (w - 1))) sy = y - (1 << w);
        end
        res = (sx > sy) ? 3'b100 : (sx == sy) ? 3'b010 : 3'b001;
        lat = nd;
        for (int k = 1; k <= nd; k++) begin
            if (((x >> (w - k * d)) & ((1 << d) - 1)) != ((y >> (w - k * d)) & ((1 << d) - 1))) begin
                lat = k;
                break;
            end
        end
    endfunction

    int   mi;
    exp_t me;
    always @(negedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) last[i] = 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (dv[i]) begin
                    ndone[i]++;
                    mi = -1;
                    for (int j = 0; j < q.size(); j++) if (mi < 0 && q[j].id == i) mi = j;
                    n_assert++;
                    if (mi < 0) begin
                        n_fail++;
                        $display("FAIL done_unexpected dut%0d got=%b", i, rv[i]);
                    end else begin
                        me = q[mi];
                        q.delete(mi);
                        if (rv[i] !== me.res || (cyc - me.start) != me.lat) begin
                            n_fail++;
                            $display("FAIL result dut%0d got res=%b lat=%0d want res=%b lat=%0d",
                                     i, rv[i], cyc - me.start, me.res, me.lat);
                        end
                    end
                    n_assert++;
                    if (!$onehot(rv[i])) begin
                        n_fail++;
                        $display("FAIL onehot dut%0d got=%b want one-hot", i, rv[i]);
                    end
                    last[i] = rv[i];
                end else begin
                    n_assert++;
                    if (rv[i] !== last[i]) begin
                        n_fail++;
                        $display("FAIL hold dut%0d got=%b want=%b", i, rv[i], last[i]);
                    end
                end
            end
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        n_assert++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout pending=%0d want=0", q.size());
            q.delete();
        end
    endtask

    task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic m,
                          input logic [2:0] res, input int lat);
        @(negedge CLK);
        b8.START = 1'b1; b8.X = x; b8.Y = y; b8.SIGNED_MODE = m;
        q.push_back('{0, res, cyc + 1, lat});
        @(negedge CLK);
        b8.START = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_assert++;
        if ({b8.BUSY, b8.DONE, rv[0]} !== 5'b0) begin
            n_fail++; $display("FAIL reset_dut0 got=%b want=00000", {b8.BUSY, b8.DONE, rv[0]});
        end
        n_assert++;
        if ({b41.BUSY, b41.DONE, rv[1]} !== 5'b0) begin
            n_fail++; $display("FAIL reset_dut1 got=%b want=00000", {b41.BUSY, b41.DONE, rv[1]});
        end
        n_assert++;
        if ({b42.BUSY, b42.DONE, rv[2]} !== 5'b0) begin
            n_fail++; $display("FAIL reset_dut2 got=%b want=00000", {b42.BUSY, b42.DONE, rv[2]});
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_unsigned();
        start8(8'hA5, 8'h25, 1'b0, 3'b100, 1);
        drain(10);
        n_assert++;
        if (rv[0] !== 3'b100) begin n_fail++; $display("FAIL unsigned_a5_25 got=%b want=100", rv[0]); end
    endtask

    task automatic test_signed();
        start8(8'h80, 8'h7F, 1'b1, 3'b001, 1);
        drain(10);
        n_assert++;
        if (rv[0] !== 3'b001) begin n_fail++; $display("FAIL signed_80_7f got=%b want=001", rv[0]); end
        start8(8'h80, 8'h7F, 1'b0, 3'b100, 1);
        drain(10);
        n_assert++;
        if (rv[0] !== 3'b100) begin n_fail++; $display("FAIL unsigned_80_7f got=%b want=100", rv[0]); end
    endtask

    task automatic test_equal();
        int nb;
        logic seen;
        nb = 0; seen = 1'b0;
        @(negedge CLK);
        b8.START = 1'b1; b8.X = 8'h3C; b8.Y = 8'h3C; b8.SIGNED_MODE = 1'b0;
        q.push_back('{0, 3'b010, cyc + 1, 4});
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            b8.START = 1'b0;
            if (b8.BUSY) nb++;
            if (b8.DONE) seen = 1'b1;
        end
        n_assert++;
        if (!seen || nb != 4) begin
            n_fail++; $display("FAIL busy_len got busy=%0d done=%0b want busy=4 done=1", nb, seen);
        end
        drain(10);
        start8(8'h01, 8'h02, 1'b0, 3'b001, 4);
        drain(10);
        n_assert++;
        if (rv[0] !== 3'b001) begin n_fail++; $display("FAIL unsigned_01_02 got=%b want=001", rv[0]); end
    endtask

    task automatic test_busy_ignore();
        int d0;
        d0 = ndone[0];
        start8(8'h3C, 8'h3C, 1'b0, 3'b010, 4);
        b8.START = 1'b1; b8.X = 8'hFF; b8.Y = 8'h00;
        repeat (3) @(negedge CLK);
        b8.START = 1'b0;
        drain(10);
        repeat (4) @(negedge CLK);
        n_assert++;
        if (ndone[0] - d0 != 1 || rv[0] !== 3'b010) begin
            n_fail++; $display("FAIL busy_ignore got dones=%0d res=%b want dones=1 res=010", ndone[0] - d0, rv[0]);
        end
    endtask

    task automatic test_rst_midrun();
        int d0;
        start8(8'h3C, 8'h3C, 1'b0, 3'b010, 4);
        @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        n_assert++;
        if ({b8.BUSY, b8.DONE, rv[0]} !== 5'b0) begin
            n_fail++; $display("FAIL async_reset got=%b want=00000", {b8.BUSY, b8.DONE, rv[0]});
        end
        q.delete();
        d0 = ndone[0];
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        n_assert++;
        if (ndone[0] != d0 || b8.BUSY !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_done got dones=%0d busy=%b want dones=0 busy=0", ndone[0] - d0, b8.BUSY);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bx [5] = '{8'h10, 8'hC0, 8'h12, 8'h7F, 8'h05};
        logic [7:0] by [5] = '{8'h10, 8'h40, 8'h13, 8'h7E, 8'h09};
        logic       bm [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0] br [5] = '{3'b010, 3'b001, 3'b001, 3'b100, 3'b001};
        int         bl [5] = '{4, 1, 4, 4, 3};
        int idx, n, d0;
        idx = 0; n = 0; d0 = ndone[0];
        while (idx < 5 && n < 100) begin
            @(negedge CLK);
            n++;
            if (!b8.BUSY) begin
                b8.START = 1'b1; b8.X = bx[idx]; b8.Y = by[idx]; b8.SIGNED_MODE = bm[idx];
                q.push_back('{0, br[idx], cyc + 1, bl[idx]});
                idx++;
            end
        end
        @(negedge CLK);
        b8.START = 1'b0;
        drain(20);
        n_assert++;
        if (idx != 5 || ndone[0] - d0 != 5) begin
            n_fail++; $display("FAIL back_to_back got issued=%0d dones=%0d want 5/5", idx, ndone[0] - d0);
        end
    endtask

    task automatic test_sweep();
        logic [2:0] r;
        int l, d1, d2;
        d1 = ndone[1]; d2 = ndone[2];
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    @(negedge CLK);
                    b41.START = 1'b1; b41.X = 4'(x); b41.Y = 4'(y); b41.SIGNED_MODE = m[0];
                    b42.START = 1'b1; b42.X = 4'(x); b42.Y = 4'(y); b42.SIGNED_MODE = m[0];
                    ref_cmp(x, y, m, 4, 1, r, l);
                    q.push_back('{1, r, cyc + 1, l});
                    ref_cmp(x, y, m, 4, 2, r, l);
                    q.push_back('{2, r, cyc + 1, l});
                    @(negedge CLK);
                    b41.START = 1'b0;
                    b42.START = 1'b0;
                    drain(12);
                end
        n_assert++;
        if (ndone[1] - d1 != 512 || ndone[2] - d2 != 512) begin
            n_fail++; $display("FAIL sweep_dones got %0d/%0d want 512/512", ndone[1] - d1, ndone[2] - d2);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin ndone[i] = 0; last[i] = 3'b000; end
        b8.START = 0;  b8.X = 0;  b8.Y = 0;  b8.SIGNED_MODE = 0;
        b41.START = 0; b41.X = 0; b41.Y = 0; b41.SIGNED_MODE = 0;
        b42.START = 0; b42.X = 0; b42.Y = 0; b42.SIGNED_MODE = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_equal();
        test_busy_ignore();
        test_rst_midrun();
        test_back_to_back();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
